// File: rtl/io_uart_pkg.sv
// io_uart_pkg: register offsets, STATUS bit positions and the shared serial FSM state type.
package io_uart_pkg;
  localparam int REG_DATA     = 0;
  localparam int REG_STATUS   = 1;
  localparam int ST_RX_AVAIL  = 0;
  localparam int ST_TX_FULL   = 1;
  localparam int ST_RX_OVR    = 2;
  localparam int ST_FRAME_ERR = 3;
  localparam int ST_TX_IDLE   = 4;
  localparam int ST_TX_OVF    = 5;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/io_uart_fifo.sv
// io_uart_fifo: small synchronous FIFO; push on full and pop on empty are ignored.
module io_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign o_full  = cnt_q == (AW+1)'(DEPTH);
  assign o_empty = cnt_q == '0;
  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & ~o_empty;
  assign o_dout  = mem_q[rd_q];
  always_ff @(posedge i_clk or negedge i_resetn)
    if (!i_resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(do_push);
      rd_q  <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // Storage holds no reset: contents are only visible through valid pointers.
  always_ff @(posedge i_clk)
    if (do_push) mem_q[wr_q] <= i_din;
endmodule

// File: rtl/io_uart.sv
// io_uart: IO-mapped 8N1 UART with TX/RX FIFOs; DATA at BASE_ADDR, STATUS at BASE_ADDR+1.
module io_uart
  import io_uart_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR  = 8'h10,
  parameter int         CLK_DIV    = 16,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic [7:0] i_bus,
  output logic [7:0] o_bus,
  output logic       o_busNOE,
  input  logic       i_ioSelect,
  input  logic [7:0] i_ioAddress,
  input  logic       i_ioNOE,
  input  logic       i_ioNWE,
  input  logic       i_rx,
  output logic       o_tx
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DIV_HALF = CW'(CLK_DIV / 2 - 1);
  logic hit_d, hit_s, rd_en, wr_en, rd_fire, wr_fire, rd_prev_q, wr_prev_q;
  logic tx_full, tx_empty, tx_pop, rx_full, rx_empty, rx_push, rx_pop;
  logic [7:0] tx_dout, rx_dout, status;
  logic rx_ovr_q, rx_ovr_d, frame_err_q, frame_err_d, tx_ovf_q, tx_ovf_d, flag_clr, fe_set;
  uart_state_t tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic tx_q, tx_d, rx_s1_q, rx_s2_q, tx_tick, rx_tick;
  assign hit_d    = i_ioSelect & (i_ioAddress == BASE_ADDR + 8'(REG_DATA));
  assign hit_s    = i_ioSelect & (i_ioAddress == BASE_ADDR + 8'(REG_STATUS));
  assign rd_en    = (hit_d | hit_s) & ~i_ioNOE;
  assign wr_en    = hit_d & ~i_ioNWE;
  // Side effects only on the first edge of each strobe assertion.
  assign rd_fire  = rd_en & ~rd_prev_q;
  assign wr_fire  = wr_en & ~wr_prev_q;
  assign rx_pop   = rd_fire & hit_d;
  assign flag_clr = rd_fire & hit_s;
  assign rx_ovr_d    = (rx_push & rx_full) | (rx_ovr_q & ~flag_clr);
  assign frame_err_d = fe_set | (frame_err_q & ~flag_clr);
  assign tx_ovf_d    = (wr_fire & tx_full) | (tx_ovf_q & ~flag_clr);
  always_comb begin
    status = '0;
    status[ST_RX_AVAIL]  = ~rx_empty;
    status[ST_TX_FULL]   = tx_full;
    status[ST_RX_OVR]    = rx_ovr_q;
    status[ST_FRAME_ERR] = frame_err_q;
    status[ST_TX_IDLE]   = (tx_st_q == IDLE) & tx_empty;
    status[ST_TX_OVF]    = tx_ovf_q;
  end
  assign o_busNOE = ~rd_en;
  assign o_bus    = !rd_en ? 8'h00 : hit_s ? status : rx_empty ? 8'h00 : rx_dout;
  assign o_tx     = tx_q;
  io_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk(i_clk), .i_resetn(i_resetn), .i_push(wr_fire), .i_pop(tx_pop), .i_din(i_bus),
    .o_dout(tx_dout), .o_full(tx_full), .o_empty(tx_empty)
  );
  io_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk(i_clk), .i_resetn(i_resetn), .i_push(rx_push), .i_pop(rx_pop), .i_din(rx_sh_q),
    .o_dout(rx_dout), .o_full(rx_full), .o_empty(rx_empty)
  );
  // The bit counter reloads itself on every bit boundary; IDLE presets it for the next frame.
  always_comb begin
    tx_tick  = tx_cnt_q == '0;
    tx_cnt_d = tx_tick ? DIV_LAST : tx_cnt_q - 1'b1;
    tx_st_d  = tx_st_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_d     = tx_q;
    tx_pop   = 1'b0;
    case (tx_st_q)
      IDLE: begin
        tx_cnt_d = DIV_LAST;
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          tx_sh_d = tx_dout;
          tx_d    = 1'b0;
          tx_st_d = START;
        end
      end
      START: if (tx_tick) begin
        tx_st_d  = DATA;
        tx_d     = tx_sh_q[0];
        tx_bit_d = '0;
      end
      DATA: if (tx_tick) begin
        tx_sh_d  = tx_sh_q >> 1;
        tx_d     = (tx_bit_q == 3'd7) ? 1'b1 : tx_sh_q[1];
        tx_st_d  = (tx_bit_q == 3'd7) ? STOP : DATA;
        tx_bit_d = tx_bit_q + 1'b1;
      end
      STOP: if (tx_tick) begin
        tx_st_d = tx_empty ? IDLE : START;
        tx_pop  = ~tx_empty;
        tx_sh_d = tx_empty ? tx_sh_q : tx_dout;
        tx_d    = tx_empty;
      end
    endcase
  end
  always_comb begin
    rx_tick  = rx_cnt_q == '0;
    rx_cnt_d = rx_tick ? DIV_LAST : rx_cnt_q - 1'b1;
    rx_st_d  = rx_st_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_push  = 1'b0;
    fe_set   = 1'b0;
    case (rx_st_q)
      IDLE: begin
        rx_cnt_d = DIV_HALF;
        rx_bit_d = '0;
        rx_st_d  = rx_s2_q ? IDLE : START;
      end
      START: if (rx_tick) rx_st_d = rx_s2_q ? IDLE : DATA;
      DATA: if (rx_tick) begin
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 1'b1;
        rx_st_d  = (rx_bit_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (rx_tick) begin
        rx_st_d = IDLE;
        rx_push = rx_s2_q;
        fe_set  = ~rx_s2_q;
      end
    endcase
  end
  always_ff @(posedge i_clk or negedge i_resetn)
    if (!i_resetn) begin
      rd_prev_q   <= 1'b0;
      wr_prev_q   <= 1'b0;
      rx_ovr_q    <= 1'b0;
      frame_err_q <= 1'b0;
      tx_ovf_q    <= 1'b0;
      tx_st_q     <= IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_sh_q     <= '0;
      tx_q        <= 1'b1;
      rx_st_q     <= IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
    end else begin
      rd_prev_q   <= rd_en;
      wr_prev_q   <= wr_en;
      rx_ovr_q    <= rx_ovr_d;
      frame_err_q <= frame_err_d;
      tx_ovf_q    <= tx_ovf_d;
      tx_st_q     <= tx_st_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_sh_q     <= tx_sh_d;
      tx_q        <= tx_d;
      rx_st_q     <= rx_st_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_sh_q     <= rx_sh_d;
      rx_s1_q     <= i_rx;
      rx_s2_q     <= rx_s1_q;
    end
endmodule

// File: tb/tb_io_uart.sv
// tb_io_uart: directed and randomized checks of io_uart against a queue-based behavioural model.
module tb_io_uart;
  localparam int DIV = 4;
  localparam int DEPTH = 4;
  localparam logic [7:0] BA = 8'h10;
  localparam logic [7:0] SA = 8'h11;
  logic clk = 1'b0, rstn = 1'b0;
  logic [7:0] bus_in = 8'h00, bus_out, addr = 8'h00;
  logic bus_noe, sel = 1'b0, noe = 1'b1, nwe = 1'b1, rx_drv = 1'b1, loop = 1'b0, tx, rx;
  logic [7:0] txq[$], rxq[$];
  logic m_rxovr = 1'b0, m_ferr = 1'b0, m_txovf = 1'b0;
  logic [7:0] b;
  int checks = 0, errors = 0;
  assign rx = loop ? tx : rx_drv;
  always #5 clk = ~clk;
  io_uart #(.BASE_ADDR(BA), .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_resetn(rstn), .i_bus(bus_in), .o_bus(bus_out), .o_busNOE(bus_noe),
    .i_ioSelect(sel), .i_ioAddress(addr), .i_ioNOE(noe), .i_ioNWE(nwe), .i_rx(rx), .o_tx(tx)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // STATUS as the rules define it: txq holds the frame on the wire plus the queued bytes.
  function automatic logic [7:0] m_status();
    int q = txq.size() > 0 ? txq.size() - 1 : 0;
    return {2'b00, m_txovf, txq.size() == 0, m_ferr, m_rxovr, q == DEPTH, rxq.size() != 0};
  endfunction
  task automatic m_rx(input logic [7:0] d, input logic stop);
    if (!stop) m_ferr = 1'b1;
    else if (rxq.size() < DEPTH) rxq.push_back(d);
    else m_rxovr = 1'b1;
  endtask
  task automatic io_write(input logic [7:0] a, input logic [7:0] d, input int hold);
    sel = 1'b1; addr = a; bus_in = d; nwe = 1'b0;
    tick(hold);
    nwe = 1'b1; sel = 1'b0;
    tick();
    if (a == BA) begin
      if (txq.size() < DEPTH + 1) txq.push_back(d);
      else m_txovf = 1'b1;
    end
  endtask
  task automatic io_read(input logic [7:0] a, input int hold, input string tag);
    logic [7:0] exp;
    if (a == SA) begin
      exp = m_status();
      m_rxovr = 1'b0; m_ferr = 1'b0; m_txovf = 1'b0;
    end else exp = rxq.size() != 0 ? rxq.pop_front() : 8'h00;
    sel = 1'b1; addr = a; noe = 1'b0;
    #1;
    chk({tag, "_noe"}, {7'b0, bus_noe}, 8'h00);
    chk(tag, bus_out, exp);
    tick(hold);
    noe = 1'b1; sel = 1'b0;
    tick();
  endtask
  task automatic check_frame(input logic [7:0] d, input logic wait_start, input string tag);
    int n = 0;
    int k;
    logic e;
    if (wait_start) while (tx !== 1'b0 && n < 40) begin tick(); n++; end
    for (int i = 0; i < 10 * DIV; i++) begin
      k = i / DIV;
      e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : d[k-1];
      chk(tag, {7'b0, tx}, {7'b0, e});
      tick();
    end
    if (txq.size() != 0) void'(txq.pop_front());
  endtask
  task automatic send_rx(input logic [7:0] d, input logic stop);
    rx_drv = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin rx_drv = d[i]; tick(DIV); end
    rx_drv = stop;
    tick(DIV);
    rx_drv = 1'b1;
    m_rx(d, stop);
  endtask
  initial begin
    tick(3);
    rstn = 1'b1;
    tick(2);
    chk("tx_idle_reset", {7'b0, tx}, 8'h01);
    chk("bus_noe_idle", {7'b0, bus_noe}, 8'h01);
    chk("bus_idle_zero", bus_out, 8'h00);
    io_read(SA, 1, "status_reset");
    io_read(BA, 1, "data_empty");
    fork
      io_write(BA, 8'hA5, 3);
      check_frame(8'hA5, 1'b1, "frame_a5");
    join
    io_read(SA, 1, "status_after_a5");
    loop = 1'b1;
    fork
      begin io_write(BA, 8'h3C, 1); io_write(BA, 8'hC3, 1); end
      begin check_frame(8'h3C, 1'b1, "frame_3c"); check_frame(8'hC3, 1'b0, "frame_c3_b2b"); end
    join
    m_rx(8'h3C, 1'b1);
    m_rx(8'hC3, 1'b1);
    tick(4);
    loop = 1'b0;
    io_read(SA, 1, "status_rx_avail");
    io_read(BA, 1, "rx_3c");
    io_read(BA, 1, "rx_c3");
    io_read(BA, 1, "rx_drained");
    io_read(SA, 1, "status_rx_empty");
    for (int i = 0; i < 6; i++) io_write(BA, 8'($urandom), 1);
    io_read(SA, 1, "status_txovf");
    io_read(SA, 1, "status_txovf_clr");
    tick(5 * 10 * DIV + 10);
    txq.delete();
    io_read(SA, 1, "status_tx_drained");
    for (int i = 0; i < 4; i++) send_rx(8'($urandom), 1'b1);
    io_write(BA, 8'($urandom), 1);
    io_write(BA, 8'($urandom), 1);
    send_rx(8'($urandom), 1'b1);
    tick(4);
    io_read(SA, 1, "status_rxovr");
    io_read(SA, 1, "status_rxovr_clr");
    tick(100);
    txq.delete();
    io_read(BA, 3, "rx_fifo0_held");
    for (int i = 1; i < 4; i++) io_read(BA, 1, "rx_fifo");
    io_read(BA, 1, "rx_fifo_empty");
    send_rx(8'($urandom), 1'b0);
    tick(4);
    io_read(SA, 1, "status_frame_err");
    io_read(SA, 1, "status_frame_err_clr");
    rx_drv = 1'b0;
    tick();
    rx_drv = 1'b1;
    tick(20);
    io_read(SA, 1, "status_after_glitch");
    io_read(BA, 1, "data_after_glitch");
    loop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      fork
        io_write(BA, b, 1);
        check_frame(b, 1'b1, "frame_rand");
      join
      m_rx(b, 1'b1);
      tick(4);
      io_read(BA, 1, "rx_rand_loop");
    end
    loop = 1'b0;
    io_write(BA, 8'h00, 1);
    tick(8);
    chk("tx_busy_pre_reset", {7'b0, tx}, 8'h00);
    #2 rstn = 1'b0;
    #1 chk("tx_async_reset", {7'b0, tx}, 8'h01);
    txq.delete(); rxq.delete();
    m_rxovr = 1'b0; m_ferr = 1'b0; m_txovf = 1'b0;
    tick(2);
    #3 rstn = 1'b1;
    tick(2);
    io_read(SA, 1, "status_post_reset");
    tick(50);
    chk("tx_frame_lost", {7'b0, tx}, 8'h01);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
